// File: rtl/fifo_wr_arbiter_if.sv
// Bundle of requester handshakes, FIFO write port, FIFO status and drain control
// seen by the round-robin FIFO write arbiter.
interface fifo_wr_arbiter_if #(
    parameter int unsigned NUM_REQ        = 4,
    parameter int unsigned FIFO_WIDTH     = 16,
    parameter int unsigned FIFO_SIZE_BITS = 5
);
    localparam int unsigned ID_W = $clog2(NUM_REQ);

    logic [NUM_REQ-1:0]            req_valid;
    logic [NUM_REQ*FIFO_WIDTH-1:0] req_data;
    logic [NUM_REQ-1:0]            req_ready;
    logic                          write;
    logic [FIFO_WIDTH-1:0]         data_in;
    logic                          fifo_full;
    logic                          fifo_empty;
    logic [FIFO_SIZE_BITS-1:0]     fifo_counter;
    logic                          drain_req;
    logic                          drain_done;
    logic [ID_W-1:0]               grant_id;

    // Arbiter side
    modport master (
        input  req_valid, req_data, fifo_full, fifo_empty, fifo_counter, drain_req,
        output req_ready, write, data_in, drain_done, grant_id
    );

    // Requester / FIFO side
    modport slave (
        output req_valid, req_data, fifo_full, fifo_empty, fifo_counter, drain_req,
        input  req_ready, write, data_in, drain_done, grant_id
    );
endinterface

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter funnelling NUM_REQ write requesters into one FIFO write port,
// with a drain mode that stops granting until the FIFO has emptied.
module fifo_wr_arbiter #(
    parameter int unsigned NUM_REQ        = 4,
    parameter int unsigned FIFO_WIDTH     = 16,
    parameter int unsigned FIFO_SIZE_BITS = 5
) (
    input  logic               clk,
    input  logic               reset,
    fifo_wr_arbiter_if.master  bus
);
    localparam int unsigned ID_W = $clog2(NUM_REQ);

    typedef enum logic [1:0] {ARB, DRAIN, DRAINED} state_t;

    state_t                state;
    logic [ID_W-1:0]       rr_ptr;
    logic [ID_W-1:0]       hi_idx;
    logic [ID_W-1:0]       lo_idx;
    logic [ID_W-1:0]       winner;
    logic                  hi_found;
    logic                  lo_found;
    logic                  can_accept;
    logic                  transfer;
    logic [FIFO_WIDTH-1:0] win_data;

    // Cyclic search: lowest valid index at/above rr_ptr, else lowest valid overall
    always_comb begin
        hi_found = 1'b0;
        lo_found = 1'b0;
        hi_idx   = '0;
        lo_idx   = '0;
        for (int i = int'(NUM_REQ) - 1; i >= 0; i--) begin
            if (bus.req_valid[i] && (ID_W'(i) >= rr_ptr)) begin
                hi_found = 1'b1;
                hi_idx   = ID_W'(i);
            end
            if (bus.req_valid[i]) begin
                lo_found = 1'b1;
                lo_idx   = ID_W'(i);
            end
        end
        winner = hi_found ? hi_idx : lo_idx;
    end

    always_comb begin
        win_data = '0;
        for (int i = 0; i < int'(NUM_REQ); i++) begin
            if (winner == ID_W'(i)) win_data = bus.req_data[i*FIFO_WIDTH +: FIFO_WIDTH];
        end
    end

    // A write already in flight into the last free slot blocks a new grant
    assign can_accept = (state == ARB) && !reset && !bus.drain_req && !bus.fifo_full &&
                        !(bus.write && (bus.fifo_counter == {FIFO_SIZE_BITS{1'b1}}));
    assign transfer   = can_accept && lo_found;

    always_comb begin
        bus.req_ready = '0;
        for (int i = 0; i < int'(NUM_REQ); i++) begin
            bus.req_ready[i] = transfer && (winner == ID_W'(i));
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            bus.write      <= 1'b0;
            bus.data_in    <= '0;
            bus.grant_id   <= '0;
            rr_ptr         <= '0;
            state          <= ARB;
            bus.drain_done <= 1'b0;
        end else begin
            bus.write <= transfer;
            if (transfer) begin
                bus.data_in  <= win_data;
                bus.grant_id <= winner;
                rr_ptr       <= (winner == ID_W'(NUM_REQ - 1)) ? '0 : winner + ID_W'(1);
            end
            case (state)
                ARB: begin
                    if (bus.drain_req) state <= DRAIN;
                end
                DRAIN: begin
                    if (bus.fifo_empty && !bus.write) begin
                        state          <= DRAINED;
                        bus.drain_done <= 1'b1;
                    end
                end
                DRAINED: begin
                    if (!bus.drain_req) begin
                        state          <= ARB;
                        bus.drain_done <= 1'b0;
                    end
                end
                default: begin
                    state          <= ARB;
                    bus.drain_done <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Scoreboard bench for fifo_wr_arbiter: a cycle model predicts grants, queues the
// expected FIFO writes and checks them when the write strobe appears.
module tb_fifo_wr_arbiter;
    localparam int unsigned NUM_REQ = 4;
    localparam int unsigned FW      = 16;
    localparam int unsigned FSB     = 5;

    typedef struct {
        logic [FW-1:0] data;
        int            id;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    fifo_wr_arbiter_if #(.NUM_REQ(NUM_REQ), .FIFO_WIDTH(FW), .FIFO_SIZE_BITS(FSB)) bus ();

    fifo_wr_arbiter #(.NUM_REQ(NUM_REQ), .FIFO_WIDTH(FW), .FIFO_SIZE_BITS(FSB)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int            n_cmp = 0;
    int            n_err = 0;
    int            m_state = 0;   // 0 ARB, 1 DRAIN, 2 DRAINED
    int            m_rr = 0;
    bit            m_write = 1'b0;
    logic [FW-1:0] m_data = '0;
    int            m_id = 0;
    logic [NUM_REQ-1:0] last_xfer = '0;
    exp_t          sb[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // One clock: check req_ready mid-cycle, advance the model, check registered outputs
    task automatic cycle();
        int w;
        int idx;
        bit acc;
        bit was_reset;
        logic [NUM_REQ-1:0] exp_ready;
        exp_t e;
        @(negedge clk);
        acc = (m_state == 0) && !reset && !bus.drain_req && !bus.fifo_full &&
              !(m_write && bus.fifo_counter == 5'd31);
        w = -1;
        for (int k = 0; k < int'(NUM_REQ); k++) begin
            idx = (m_rr + k) % int'(NUM_REQ);
            if (w < 0 && bus.req_valid[idx]) w = idx;
        end
        exp_ready = '0;
        if (acc && w >= 0) exp_ready[w] = 1'b1;
        check("req_ready", 32'(bus.req_ready), 32'(exp_ready));
        last_xfer = exp_ready & bus.req_valid;
        if (|exp_ready) sb.push_back('{bus.req_data[w*FW +: FW], w});
        @(posedge clk);
        was_reset = reset;
        if (reset) begin
            m_write = 1'b0; m_rr = 0; m_state = 0; m_data = '0; m_id = 0;
            sb.delete();
        end else begin
            case (m_state)
                0: if (bus.drain_req) m_state = 1;
                1: if (bus.fifo_empty && !m_write) m_state = 2;
                2: if (!bus.drain_req) m_state = 0;
                default: m_state = 0;
            endcase
            m_write = |exp_ready;
            if (m_write) begin
                m_rr = (w + 1) % int'(NUM_REQ);
                if (sb.size() == 0) begin
                    check("sb_nonempty", 32'd0, 32'd1);
                end else begin
                    e = sb.pop_front();
                    m_data = e.data;
                    m_id = e.id;
                end
            end
        end
        #1;
        check(was_reset ? "rst_write" : "write", 32'(bus.write), 32'(m_write));
        check("data_in", 32'(bus.data_in), 32'(m_data));
        check("grant_id", 32'(bus.grant_id), 32'(m_id));
        check("drain_done", 32'(bus.drain_done), 32'(m_state == 2));
    endtask

    initial begin
        reset            = 1'b1;
        bus.req_valid    = '0;
        bus.req_data     = '0;
        bus.fifo_full    = 1'b0;
        bus.fifo_empty   = 1'b1;
        bus.fifo_counter = '0;
        bus.drain_req    = 1'b0;
        repeat (2) cycle();
        reset = 1'b0;

        // All requesters valid: strict rotation from requester 0
        for (int i = 0; i < int'(NUM_REQ); i++) bus.req_data[i*FW +: FW] = FW'(16'h1000 + i);
        bus.req_valid = '1;
        for (int k = 0; k < 8; k++) begin
            cycle();
            check("rot_id", 32'(bus.grant_id), 32'(k % 4));
            check("rot_write", 32'(bus.write), 32'd1);
        end
        bus.req_valid = '0;
        cycle();

        // Single requester 2
        bus.req_data[2*FW +: FW] = 16'hA5A5;
        bus.req_valid = 4'b0100;
        cycle();
        bus.req_valid = '0;
        check("single_data", 32'(bus.data_in), 32'h0000_A5A5);
        check("single_id", 32'(bus.grant_id), 32'd2);
        cycle();

        // Full boundary: in-flight write into last slot, then full
        bus.req_valid = '1;
        cycle();
        bus.fifo_counter = 5'd31;
        bus.fifo_empty = 1'b0;
        cycle();
        bus.fifo_full = 1'b1;
        repeat (3) begin
            cycle();
            check("full_nowrite", 32'(bus.write), 32'd0);
        end
        bus.fifo_full = 1'b0;
        bus.fifo_counter = 5'd0;
        bus.fifo_empty = 1'b1;
        repeat (2) cycle();

        // Drain with 3 words in the FIFO
        bus.drain_req = 1'b1;
        bus.fifo_empty = 1'b0;
        bus.fifo_counter = 5'd3;
        repeat (3) cycle();
        bus.fifo_empty = 1'b1;
        bus.fifo_counter = 5'd0;
        cycle();
        check("drained", 32'(bus.drain_done), 32'd1);
        cycle();
        bus.drain_req = 1'b0;
        cycle();
        check("undrain", 32'(bus.drain_done), 32'd0);
        repeat (2) cycle();

        // Mid-operation reset once rr_ptr reaches 2
        for (int k = 0; k < 8 && m_rr != 2; k++) cycle();
        check("rr_at_2", 32'(m_rr), 32'd2);
        reset = 1'b1;
        cycle();
        check("rst_data", 32'(bus.data_in), 32'd0);
        reset = 1'b0;
        cycle();
        check("rst_first", 32'(bus.grant_id), 32'd0);

        // Random traffic honouring hold-until-accepted
        for (int c = 0; c < 60; c++) begin
            for (int i = 0; i < int'(NUM_REQ); i++) begin
                if (!bus.req_valid[i] || last_xfer[i]) begin
                    bus.req_valid[i] = 1'($urandom_range(0, 1));
                    bus.req_data[i*FW +: FW] = FW'($urandom);
                end
            end
            bus.fifo_full    = ($urandom_range(0, 7) == 0);
            bus.fifo_counter = FSB'($urandom_range(0, 31));
            bus.fifo_empty   = (bus.fifo_counter == 0) && !bus.fifo_full;
            cycle();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
